atan2_cordic_q22: RTL and testbench

Iterative CORDIC vectoring engine: converts a Cartesian pair (x, y) in Q1.23 into a phase angle in Q2.22 and a magnitude in Q2.22. It is the inverse of the polynomial sin/cos generator, so oscillator and phase-tracking chains can recover phase and amplitude from I/Q samples. It sits in the Math module, one result per request, with valid/ready handshakes on both sides.

---
 rtl/atan2_cordic_q22_pkg.sv | 45 ++++
 rtl/atan2_cordic_q22_cordic_vec_step.sv | 33 +++
 rtl/atan2_cordic_q22.sv | 138 +++++++++++++
 tb/tb_atan2_cordic_q22.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/atan2_cordic_q22_pkg.sv
// Shared constants, state encoding and helpers for the atan2 CORDIC vectoring engine.
// CORDIC_GAIN_COMP_EN adds the COMP state used for gain compensation.
package atan2_cordic_q22_pkg;

    localparam int unsigned IO_W   = 24;
    localparam int unsigned XY_W   = 27;
    localparam int unsigned Z_W    = 25;
    localparam int unsigned ITER_W = 5;
    localparam int unsigned PROD_W = XY_W + IO_W;

    localparam logic signed [Z_W-1:0] Q22_ONE             = 25'sh0400000;
    localparam logic [IO_W-1:0]       CORDIC_INV_GAIN_Q23 = 24'h4DBA76;

    // atan(2^-i)/pi in Q2.22, rounded to nearest
    localparam logic signed [Z_W-1:0] ATAN_TAB_Q22 [0:23] = '{
        25'sd1048576, 25'sd619011, 25'sd327068, 25'sd166025,
        25'sd83335,   25'sd41708,  25'sd20859,  25'sd10430,
        25'sd5215,    25'sd2608,   25'sd1304,   25'sd652,
        25'sd326,     25'sd163,    25'sd81,     25'sd41,
        25'sd20,      25'sd10,     25'sd5,      25'sd3,
        25'sd1,       25'sd1,      25'sd0,      25'sd0
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
`ifdef CORDIC_GAIN_COMP_EN
        COMP = 2'd2,
`endif
        DONE = 2'd3
    } cordic_state_t;

    // Q3.23 datapath value to unsigned Q2.22 magnitude, saturating
    function automatic logic [IO_W-1:0] sat_mag(input logic signed [XY_W-1:0] x);
        logic [XY_W-1:0] half;
        half = unsigned'(x) >> 1;
        if (x[XY_W-1])
            return '0;
        else if (|half[XY_W-1:IO_W])
            return '1;
        else
            return half[IO_W-1:0];
    endfunction

endpackage

// File: rtl/atan2_cordic_q22_cordic_vec_step.sv
// One combinational CORDIC vectoring micro-rotation driving y toward zero.
module atan2_cordic_q22_cordic_vec_step
    import atan2_cordic_q22_pkg::*;
(
    input  logic signed [XY_W-1:0]   x,
    input  logic signed [XY_W-1:0]   y,
    input  logic signed [Z_W-1:0]    z,
    input  logic        [ITER_W-1:0] i,
    output logic signed [XY_W-1:0]   x_next,
    output logic signed [XY_W-1:0]   y_next,
    output logic signed [Z_W-1:0]    z_next
);

    logic signed [XY_W-1:0] x_sh;
    logic signed [XY_W-1:0] y_sh;
    logic signed [Z_W-1:0]  ang;

    always_comb begin
        x_sh = x >>> i;
        y_sh = y >>> i;
        ang  = (i < ITER_W'(24)) ? ATAN_TAB_Q22[i] : '0;
        if (!y[XY_W-1]) begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + ang;
        end else begin
            x_next = x - y_sh;
            y_next = y + x_sh;
            z_next = z - ang;
        end
    end

endmodule

// File: rtl/atan2_cordic_q22.sv
// Iterative CORDIC atan2/magnitude engine: Q1.23 (x, y) in, Q2.22 angle and magnitude out.
// CORDIC_GAIN_COMP_EN: adds a COMP cycle scaling the magnitude by 1/K.
module atan2_cordic_q22
    import atan2_cordic_q22_pkg::*;
#(
    parameter int unsigned N_ITER = 22
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IO_W-1:0] x_in,
    input  logic [IO_W-1:0] y_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IO_W-1:0] angle_out,
    output logic [IO_W-1:0] mag_out
);

    cordic_state_t state_q, state_nxt;
    logic          in_ready_q, out_valid_q, in_ready_nxt, out_valid_nxt;

    logic signed [XY_W-1:0] x_q, y_q, x_ext, y_ext, x0, y0, x_step, y_step, x_res;
    logic signed [Z_W-1:0]  z_q, z0, z_step, z_res;
    logic [ITER_W-1:0]      iter_q;
    logic                   zero_q;
    logic [IO_W-1:0]        angle_q, mag_q;
    logic                   accept_c, last_c, load_c;

    assign accept_c = (state_q == IDLE) && in_valid;
    assign last_c   = (iter_q == ITER_W'(N_ITER - 1));

    assign x_ext = XY_W'($signed(x_in));
    assign y_ext = XY_W'($signed(y_in));

    // Fold left half-plane inputs into the right half-plane with a +/-pi offset
    always_comb begin
        x0 = x_ext;
        y0 = y_ext;
        z0 = '0;
        if (x_ext[XY_W-1]) begin
            x0 = -x_ext;
            y0 = -y_ext;
            z0 = y_ext[XY_W-1] ? -Q22_ONE : Q22_ONE;
        end
    end

    atan2_cordic_q22_cordic_vec_step u_step (
        .x      (x_q),
        .y      (y_q),
        .z      (z_q),
        .i      (iter_q),
        .x_next (x_step),
        .y_next (y_step),
        .z_next (z_step)
    );

`ifdef CORDIC_GAIN_COMP_EN
    logic [PROD_W-1:0] prod_c;
    assign prod_c = PROD_W'(unsigned'(x_q)) * PROD_W'(CORDIC_INV_GAIN_Q23);
    assign x_res  = $signed(XY_W'(prod_c >> 23));
    assign z_res  = z_q;
    assign load_c = (state_q == COMP);
`else
    assign x_res  = x_step;
    assign z_res  = z_step;
    assign load_c = (state_q == ITER) && last_c;
`endif

    // State register plus registered handshake decodes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            in_ready_q  <= in_ready_nxt;
            out_valid_q <= out_valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: if (in_valid) state_nxt = ITER;
`ifdef CORDIC_GAIN_COMP_EN
            ITER: if (last_c) state_nxt = COMP;
            COMP: state_nxt = DONE;
`else
            ITER: if (last_c) state_nxt = DONE;
`endif
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready_nxt  = (state_nxt == IDLE);
        out_valid_nxt = (state_nxt == DONE);
    end

    // Datapath: capture with pre-rotation, rotate, then latch the result once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            iter_q  <= '0;
            zero_q  <= 1'b0;
            angle_q <= '0;
            mag_q   <= '0;
        end else begin
            if (accept_c) begin
                x_q    <= x0;
                y_q    <= y0;
                z_q    <= z0;
                iter_q <= '0;
                zero_q <= (x_in == '0) && (y_in == '0);
            end else if (state_q == ITER) begin
                x_q    <= x_step;
                y_q    <= y_step;
                z_q    <= z_step;
                iter_q <= iter_q + ITER_W'(1);
            end
            if (load_c) begin
                angle_q <= zero_q ? '0 : z_res[IO_W-1:0];
                mag_q   <= zero_q ? '0 : sat_mag(x_res);
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign angle_out = angle_q;
    assign mag_out   = mag_q;

endmodule

// File: tb/tb_atan2_cordic_q22.sv
// Directed self-checking bench for atan2_cordic_q22 (default N_ITER = 22).
module tb_atan2_cordic_q22;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int          LAT      = 23;
    localparam logic [23:0] MAG_HALF = 24'h200000;   // 0.5
    localparam logic [23:0] MAG_EXT  = 24'd5931642;  // sqrt(2)
`else
    localparam int          LAT      = 22;
    localparam logic [23:0] MAG_HALF = 24'h34B242;   // 0.5*K, K = 1.6467602581
    localparam logic [23:0] MAG_EXT  = 24'd9767992;  // sqrt(2)*K
`endif

    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [23:0] x_in, y_in, angle_out, mag_out;

    int nvec = 0;
    int nmis = 0;

    atan2_cordic_q22 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .angle_out (angle_out),
        .mag_out   (mag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and wait (bounded) for its result
    task automatic do_req(input logic [23:0] x, input logic [23:0] y, input logic rdy,
                          output logic [23:0] ang, output logic [23:0] mag, output int lat,
                          output logic busy_ir, output logic ov_after, output logic ir_after);
        @(negedge clk);
        x_in = x; y_in = y; in_valid = 1'b1; out_ready = rdy;
        @(posedge clk); #1;
        in_valid = 1'b0;
        busy_ir = in_ready;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        ang = angle_out;
        mag = mag_out;
        ov_after = out_valid;
        ir_after = in_ready;
        if (rdy) begin
            @(posedge clk); #1;
            ov_after = out_valid;
            ir_after = in_ready;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x_in = '0; y_in = '0;
        repeat (3) @(posedge clk);
        #1;
        nvec++; if (in_ready !== 1'b1) begin nmis++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        nvec++; if (angle_out !== 24'h0) begin nmis++; $display("FAIL rst_angle: got %h want 000000", angle_out); end
        nvec++; if (mag_out !== 24'h0) begin nmis++; $display("FAIL rst_mag: got %h want 000000", mag_out); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        nvec++; if (in_ready !== 1'b1) begin nmis++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_pos_real;
        logic [23:0] a, m; int lat, d; logic bi, ov, ir;
        do_req(24'h400000, 24'h000000, 1'b1, a, m, lat, bi, ov, ir);
        nvec++; if (lat !== LAT) begin nmis++; $display("FAIL pos_real_lat: got %0d want %0d", lat, LAT); end
        nvec++; if (bi !== 1'b0) begin nmis++; $display("FAIL busy_in_ready: got %b want 0", bi); end
        d = int'($signed(a - 24'h000000));
        nvec++; if (d > 4 || d < -4) begin nmis++; $display("FAIL pos_real_angle: got %h want 000000+-4", a); end
        d = int'($signed(m - MAG_HALF));
        nvec++; if (d > 4 || d < -4) begin nmis++; $display("FAIL pos_real_mag: got %h want %h+-4", m, MAG_HALF); end
        nvec++; if (ov !== 1'b0) begin nmis++; $display("FAIL pos_real_consumed: got out_valid %b want 0", ov); end
        nvec++; if (ir !== 1'b1) begin nmis++; $display("FAIL pos_real_idle: got in_ready %b want 1", ir); end
    endtask

    task automatic test_pos_imag;
        logic [23:0] a, m; int lat, d; logic bi, ov, ir;
        do_req(24'h000000, 24'h400000, 1'b1, a, m, lat, bi, ov, ir);
        d = int'($signed(a - 24'h200000));
        nvec++; if (d > 4 || d < -4) begin nmis++; $display("FAIL pos_imag_angle: got %h want 200000+-4", a); end
        d = int'($signed(m - MAG_HALF));
        nvec++; if (d > 4 || d < -4) begin nmis++; $display("FAIL pos_imag_mag: got %h want %h+-4", m, MAG_HALF); end
    endtask

    task automatic test_neg_real;
        logic [23:0] a, m; int lat, d; logic bi, ov, ir;
        do_req(24'hC00000, 24'h000000, 1'b1, a, m, lat, bi, ov, ir);
        d = int'($signed(a - 24'h400000));
        nvec++; if (d > 4 || d < -4) begin nmis++; $display("FAIL neg_real_angle: got %h want 400000+-4", a); end
        d = int'($signed(m - MAG_HALF));
        nvec++; if (d > 4 || d < -4) begin nmis++; $display("FAIL neg_real_mag: got %h want %h+-4", m, MAG_HALF); end
        do_req(24'hC00000, 24'hFFFFFF, 1'b1, a, m, lat, bi, ov, ir);
        d = int'($signed(a - 24'hC00000));
        nvec++; if (d > 4 || d < -4) begin nmis++; $display("FAIL wrap_angle: got %h want C00000+-4", a); end
        nvec++; if (a[23] !== 1'b1) begin nmis++; $display("FAIL wrap_sign: got %b want 1", a[23]); end
    endtask

    task automatic test_extremes;
        logic [23:0] a, m; int lat, d; logic bi, ov, ir;
        do_req(24'h000000, 24'h000000, 1'b1, a, m, lat, bi, ov, ir);
        nvec++; if (a !== 24'h0) begin nmis++; $display("FAIL zero_angle: got %h want 000000", a); end
        nvec++; if (m !== 24'h0) begin nmis++; $display("FAIL zero_mag: got %h want 000000", m); end
        nvec++; if (lat !== LAT) begin nmis++; $display("FAIL zero_lat: got %0d want %0d", lat, LAT); end
        do_req(24'h800000, 24'h800000, 1'b1, a, m, lat, bi, ov, ir);
        d = int'($signed(a - 24'hD00000));
        nvec++; if (d > 4 || d < -4) begin nmis++; $display("FAIL ext_angle: got %h want D00000+-4", a); end
        d = int'($signed(m - MAG_EXT));
        nvec++; if (d > 64 || d < -64) begin nmis++; $display("FAIL ext_mag: got %h want %h+-64", m, MAG_EXT); end
    endtask

    task automatic test_backpressure;
        logic [23:0] a, m; int lat, d; logic bi, ov, ir; logic seen;
        do_req(24'h400000, 24'h400000, 1'b0, a, m, lat, bi, ov, ir);
        nvec++; if (lat !== LAT) begin nmis++; $display("FAIL bp_lat: got %0d want %0d", lat, LAT); end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            d = int'($signed(angle_out - 24'h100000));
            nvec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || d > 4 || d < -4) begin
                nmis++;
                $display("FAIL bp_hold[%0d]: got v=%b r=%b ang=%h want v=1 r=0 ang=100000+-4",
                         k, out_valid, in_ready, angle_out);
            end
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        nvec++; if (in_ready !== 1'b1) begin nmis++; $display("FAIL bp_release_idle: got %b want 1", in_ready); end
        seen = 1'b0;
        repeat (5) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        nvec++; if (seen !== 1'b0) begin nmis++; $display("FAIL bp_single_xfer: got extra out_valid %b want 0", seen); end
    endtask

    task automatic test_reset_mid;
        logic [23:0] a, m; int lat, d; logic bi, ov, ir; logic seen;
        @(negedge clk);
        x_in = 24'h400000; y_in = 24'h000000; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        nvec++; if (in_ready !== 1'b1) begin nmis++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
        nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
        nvec++; if (angle_out !== 24'h0) begin nmis++; $display("FAIL mid_rst_angle: got %h want 000000", angle_out); end
        nvec++; if (mag_out !== 24'h0) begin nmis++; $display("FAIL mid_rst_mag: got %h want 000000", mag_out); end
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        nvec++; if (seen !== 1'b0) begin nmis++; $display("FAIL mid_rst_no_result: got out_valid %b want 0", seen); end
        do_req(24'h000000, 24'hC00000, 1'b1, a, m, lat, bi, ov, ir);
        nvec++; if (lat !== LAT) begin nmis++; $display("FAIL after_rst_lat: got %0d want %0d", lat, LAT); end
        d = int'($signed(a - 24'hE00000));
        nvec++; if (d > 4 || d < -4) begin nmis++; $display("FAIL after_rst_angle: got %h want E00000+-4", a); end
        d = int'($signed(m - MAG_HALF));
        nvec++; if (d > 4 || d < -4) begin nmis++; $display("FAIL after_rst_mag: got %h want %h+-4", m, MAG_HALF); end
    endtask

    initial begin
        test_reset();
        test_pos_real();
        test_pos_imag();
        test_neg_real();
        test_extremes();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
